// File: rtl/seg_pattern_decoder.sv
// Receive-side 7-segment decoder: synchronizes and debounces a segment bus,
// maps stable patterns to symbol indices, and tracks dwell time and +1 sequencing.
module seg_pattern_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int DWELL_W       = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         seg_in,
    output logic [3:0]         value_out,
    output logic               value_valid,
    output logic               value_err,
    output logic               seq_err,
    output logic               locked,
    output logic [DWELL_W-1:0] dwell_count
);

    localparam int                 STAB_W    = $clog2(STABLE_CYCLES) + 1;
    localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
    localparam logic [6:0]         BLANK     = 7'b0000000;

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] idx;
    } dec_t;

    // 1011110 is shared by 10 and 13; it reads as 13 only right after a 12.
    function automatic dec_t decode(input logic [6:0] pat, input logic amb_13);
        dec_t d;
        d.legal = 1'b1;
        d.idx   = 4'd0;
        case (pat)
            7'b0111111: d.idx = 4'd0;
            7'b0000110: d.idx = 4'd1;
            7'b1011011: d.idx = 4'd2;
            7'b1001111: d.idx = 4'd3;
            7'b1100110: d.idx = 4'd4;
            7'b1101101: d.idx = 4'd5;
            7'b1111101: d.idx = 4'd6;
            7'b0000111: d.idx = 4'd7;
            7'b1111111: d.idx = 4'd8;
            7'b1101111: d.idx = 4'd9;
            7'b1011110: d.idx = amb_13 ? 4'd13 : 4'd10;
            7'b0111001: d.idx = 4'd11;
            7'b1110110: d.idx = 4'd12;
            7'b1111011: d.idx = 4'd14;
            7'b1111110: d.idx = 4'd15;
            default:    d.legal = 1'b0;
        endcase
        return d;
    endfunction

    logic [6:0]         sync_p [SYNC_STAGES];
    logic [6:0]         synced;
    logic [6:0]         cand;
    logic [6:0]         cand_next;
    logic [6:0]         last_pat;
    logic [STAB_W-1:0]  stab;
    logic [STAB_W-1:0]  stab_next;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               has_prev;
    logic               accept;
    logic               changed;
    logic               new_sym;
    logic               seq_bad;
    dec_t               dec;
    state_t             state;
    state_t             state_next;

    // Stage p0..pN: metastability synchronizer on the asynchronous bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
        end else begin
            sync_p[0] <= seg_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
        end
    end

    assign synced = sync_p[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Stability qualification: any change of the synced bus restarts settling
    always_comb begin
        state_next = state;
        cand_next  = cand;
        stab_next  = stab;
        accept     = 1'b0;
        if (synced != cand) begin
            cand_next  = synced;
            stab_next  = '0;
            state_next = SETTLE;
        end else if (state == SETTLE) begin
            if (stab == STAB_LAST) begin
                accept     = 1'b1;
                state_next = LOCKED;
            end else begin
                stab_next = stab + 1'b1;
            end
        end
    end

    always_comb begin
        dec     = decode(cand, has_prev && (value_out == 4'd12));
        changed = accept && (cand != last_pat);
        new_sym = changed && (cand != BLANK) && dec.legal;
        seq_bad = has_prev && (dec.idx != value_out + 4'd1);
    end

    // Acceptance: pulses, symbol/lock state and dwell measurement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand        <= '0;
            stab        <= '0;
            last_pat    <= '0;
            dwell_cnt   <= '0;
            has_prev    <= 1'b0;
            value_out   <= '0;
            value_valid <= 1'b0;
            value_err   <= 1'b0;
            seq_err     <= 1'b0;
            locked      <= 1'b0;
            dwell_count <= '0;
        end else begin
            cand        <= cand_next;
            stab        <= stab_next;
            value_valid <= 1'b0;
            value_err   <= 1'b0;
            seq_err     <= 1'b0;

            if (new_sym) begin
                dwell_cnt <= DWELL_ONE;
            end else if (!accept && (dwell_cnt != DWELL_MAX)) begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end

            // Re-accepting the last pattern is glitch recovery and changes nothing.
            if (changed) begin
                last_pat <= cand;
                if (cand == BLANK) begin
                    locked <= 1'b0;
                end else if (dec.legal) begin
                    value_out   <= dec.idx;
                    value_valid <= 1'b1;
                    seq_err     <= seq_bad;
                    dwell_count <= dwell_cnt;
                    has_prev    <= 1'b1;
                    locked      <= 1'b1;
                end else begin
                    value_err <= 1'b1;
                    locked    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Directed scoreboard bench for seg_pattern_decoder; a second instance with a
// 4-bit dwell counter shares the stimulus to exercise dwell saturation.
module tb_seg_pattern_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_in = 7'b0;

    logic [3:0]  value_out,   value_out4;
    logic        value_valid, value_valid4;
    logic        value_err,   value_err4;
    logic        seq_err,     seq_err4;
    logic        locked,      locked4;
    logic [25:0] dwell_count;
    logic [3:0]  dwell_count4;

    seg_pattern_decoder dut (
        .clk(clk), .rst(rst), .seg_in(seg_in),
        .value_out(value_out), .value_valid(value_valid), .value_err(value_err),
        .seq_err(seq_err), .locked(locked), .dwell_count(dwell_count)
    );

    seg_pattern_decoder #(.DWELL_W(4)) dut4 (
        .clk(clk), .rst(rst), .seg_in(seg_in),
        .value_out(value_out4), .value_valid(value_valid4), .value_err(value_err4),
        .seq_err(seq_err4), .locked(locked4), .dwell_count(dwell_count4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [3:0] val;
        logic       seq;
        int         dwell;
        int         exp_cyc;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] enc(input int idx);
        case (idx)
            0:  return 7'b0111111;
            1:  return 7'b0000110;
            2:  return 7'b1011011;
            3:  return 7'b1001111;
            4:  return 7'b1100110;
            5:  return 7'b1101101;
            6:  return 7'b1111101;
            7:  return 7'b0000111;
            8:  return 7'b1111111;
            9:  return 7'b1101111;
            10: return 7'b1011110;
            11: return 7'b0111001;
            12: return 7'b1110110;
            13: return 7'b1011110;
            14: return 7'b1111011;
            default: return 7'b1111110;
        endcase
    endfunction

    // A change driven at negedge with cyc=k is sampled at edge k+1 and pulses after edge k+7.
    task automatic exp_v(input int idx, input bit seq, input int dwell);
        exp_t e;
        e.is_err = 1'b0; e.val = 4'(idx); e.seq = seq; e.dwell = dwell; e.exp_cyc = cyc + 7;
        sb.push_back(e);
    endtask

    task automatic exp_e(input int held_val);
        exp_t e;
        e.is_err = 1'b1; e.val = 4'(held_val); e.seq = 1'b0; e.dwell = -1; e.exp_cyc = cyc + 7;
        sb.push_back(e);
    endtask

    task automatic step(input logic [6:0] pat, input int hold);
        seg_in = pat;
        repeat (hold) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sb.size() == 0) begin
                check("spurious_pulse", 32'({value_valid, value_err}), 0);
                check("spurious_pulse_w4", 32'({value_valid4, value_err4}), 0);
            end else if (value_valid || value_err) begin
                e = sb.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.exp_cyc));
                check("pulse_valid", 32'(value_valid), 32'(!e.is_err));
                check("pulse_err", 32'(value_err), 32'(e.is_err));
                check("value_out", 32'(value_out), 32'(e.val));
                check("seq_err", 32'(seq_err), 32'(e.seq));
                check("locked_at_pulse", 32'(locked), 32'(!e.is_err));
                check("w4_valid", 32'(value_valid4), 32'(!e.is_err));
                check("w4_value_out", 32'(value_out4), 32'(e.val));
                check("w4_seq_err", 32'(seq_err4), 32'(e.seq));
                if (e.dwell >= 0) begin
                    check("dwell_count", 32'(dwell_count), 32'(e.dwell));
                    check("dwell_count_w4", 32'(dwell_count4), 32'(e.dwell > 15 ? 15 : e.dwell));
                end
            end else begin
                check("pulse_late", 32'(cyc > sb[0].exp_cyc), 0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        seg_in = 7'b0;
        repeat (3) @(negedge clk);
        check("rst_value_out", 32'(value_out), 0);
        check("rst_value_valid", 32'(value_valid), 0);
        check("rst_value_err", 32'(value_err), 0);
        check("rst_seq_err", 32'(seq_err), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_dwell", 32'(dwell_count), 0);
        check("rst_dwell_w4", 32'(dwell_count4), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // First symbol after reset
        exp_v(0, 1'b0, -1);
        step(enc(0), 10);
        check("first_locked", 32'(locked), 1);
        check("first_value", 32'(value_out), 0);

        // Sweep 1..15 and wrap to 0; 1011110 gives 13 after 12 and 10 after 9
        for (int i = 1; i <= 16; i++) begin
            exp_v(i % 16, 1'b0, (i == 1) ? 10 : 100);
            step(enc(i % 16), 100);
        end
        check("sweep_locked", 32'(locked), 1);
        check("sweep_value", 32'(value_out), 0);

        // Short glitch while locked on 3
        exp_v(1, 1'b0, 100);
        step(enc(1), 20);
        exp_v(2, 1'b0, 20);
        step(enc(2), 20);
        exp_v(3, 1'b0, 20);
        step(enc(3), 20);
        step(7'b1111111, 2);
        step(enc(3), 20);
        check("glitch_value", 32'(value_out), 3);
        check("glitch_locked", 32'(locked), 1);

        // Stable illegal pattern, then a legal symbol
        exp_e(3);
        step(7'b1010101, 20);
        check("illegal_locked", 32'(locked), 0);
        check("illegal_value", 32'(value_out), 3);
        exp_v(4, 1'b0, -1);
        step(enc(4), 20);
        check("after_illegal_locked", 32'(locked), 1);

        // Out-of-sequence symbols, 40-cycle hold, then blank
        exp_v(2, 1'b1, 20);
        step(enc(2), 40);
        exp_v(5, 1'b1, 40);
        step(enc(5), 30);
        step(7'b0000000, 20);
        check("blank_locked", 32'(locked), 0);
        check("blank_value", 32'(value_out), 5);

        // Reset two cycles before acceptance of a new pattern
        seg_in = enc(6);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_value_out", 32'(value_out), 0);
        check("midrst_valid", 32'(value_valid), 0);
        check("midrst_locked", 32'(locked), 0);
        check("midrst_dwell", 32'(dwell_count), 0);
        check("midrst_locked_w4", 32'(locked4), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_v(6, 1'b0, -1);
        step(enc(6), 30);
        exp_v(7, 1'b0, 30);
        step(enc(7), 30);
        exp_v(9, 1'b1, 30);
        step(enc(9), 20);
        check("final_value", 32'(value_out), 9);
        check("final_locked", 32'(locked), 1);
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_pattern_decoder.md
Name: seg_pattern_decoder

Overview:
- Receive-side counterpart of the 7-segment letter/digit encoder.
- Samples a 7-bit segment bus driven by an encoder, synchronizes and debounces it, and maps each stable pattern back to its 4-bit symbol index (0..15, shown as A..P).
- Reports how long each symbol was held and whether symbols arrive in the expected +1 sequence.
- Used as an on-chip loopback checker and as an input-side decoder for segment buses from external boards.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on seg_in; legal range 2..3.
- STABLE_CYCLES, 4: consecutive equal synced samples required to accept a pattern; legal range ≥2.
- DWELL_W, 26: width of the dwell counter and of dwell_count.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- seg_in  input  7  segment bus, bit6=g .. bit0=a, active-high, asynchronous to clk.
- value_out  output  4  last accepted symbol index.
- value_valid  output  1  one-cycle pulse when a new legal symbol is accepted.
- value_err  output  1  one-cycle pulse when a stable illegal pattern is accepted.
- seq_err  output  1  one-cycle pulse, coincident with value_valid, when the symbol is not (previous+1) mod 16.
- locked  output  1  high while the accepted pattern is a legal, non-blank symbol.
- dwell_count  output  DWELL_W  cycles between the previous and the current value_valid.

Behaviour:
- Reset (async assert, sync release):
  - Synchronizer, candidate and last-accepted pattern = 7'b0.
  - value_out=0; value_valid, value_err, seq_err, locked = 0; dwell_count=0.
  - Dwell counter=0; has_prev=0; FSM=IDLE.
  - Reset dominates every simultaneous event.
- Decode table (pattern -> index):
  - 0111111->0, 0000110->1, 1011011->2, 1001111->3, 1100110->4, 1101101->5, 1111101->6, 0000111->7.
  - 1111111->8, 1101111->9, 1011110->10/13, 0111001->11, 1110110->12, 1111011->14, 1111110->15.
  - 0000000 = blank.
  - Any other pattern is illegal.
- Ambiguous pattern 1011110: decodes to 13 if has_prev=1 and the previous accepted index is 12; otherwise it decodes to 10.
- FSM states:
  - IDLE: no pattern accepted yet.
  - SETTLE: candidate is counting stability.
  - LOCKED: pattern accepted.
- Every cycle, synced != candidate: candidate<=synced, stab<=0, state->SETTLE. This applies from any state.
- In SETTLE with synced == candidate: stab increments. When stab == STABLE_CYCLES-1, accept; state->LOCKED.
- Accept, legal non-blank pattern that differs from the last accepted pattern:
  - value_out<=index; value_valid=1 for one cycle.
  - seq_err=1 iff has_prev && index != prev+1 (4-bit wrap, 15->0 legal).
  - dwell_count<=dwell counter; dwell counter<=1; has_prev<=1; locked<=1.
- Accept, pattern equal to the last accepted pattern (glitch recovery): no pulses, no dwell reset; locked restored to its prior value.
- Accept, blank: locked<=0; no pulses; value_out held; last-accepted<=blank.
- Accept, illegal: value_err=1 for one cycle; locked<=0; value_out, has_prev and prev held; last-accepted<=pattern.
- Dwell counter: increments every non-accept cycle and saturates at 2^DWELL_W-1. It runs in all states.
- Latency: a seg_in change sampled at edge 1 produces value_valid high after edge SYNC_STAGES+STABLE_CYCLES+1 (7 with defaults), provided seg_in holds.
- Glitches shorter than STABLE_CYCLES synced cycles never cause a pulse.
- Pulses never assert in IDLE or SETTLE, and never twice for one acceptance.
- Reset mid-SETTLE discards the candidate; after release the FSM returns to IDLE and the first acceptance has seq_err=0.

Test Plan:
- Reset, then seg_in=0111111 held 10 cycles -> value_valid pulse after edge 7 with value_out=0, seq_err=0, locked=1.
- Encoder-style sweep of indices 0..15 then 0, each held 100 cycles -> 17 value_valid pulses with seq_err=0 throughout (including 15->0). Pattern 1011110 after 12 yields 13; after 9 yields 10. dwell_count=100 from the second pulse onward.
- Locked on index 3; seg_in pulses 1111111 for 2 cycles, then returns to 1001111 -> no value_valid, value_err or seq_err; value_out stays 3; locked stays 1.
- Stable illegal pattern 1010101 -> single value_err pulse, locked=0, value_out unchanged. Next stable 1100110 -> value_valid, value_out=4, seq_err per prev.
- Jump from index 2 to index 5 -> value_valid with seq_err=1. Blank 0000000 held -> locked=0, no pulses.
- Assert rst while in SETTLE with a new pattern two cycles from acceptance -> all outputs 0 immediately and no pulse after release until STABLE_CYCLES re-qualify. DWELL_W=4 with a 40-cycle hold -> dwell_count=15 (saturated).
